// File: rtl/dual_port_arbiter.sv
// Arbiter in front of a dual-port memory shared by two clients.
// After reset it walks every address writing zero (CLEAR), then enters RUN, where
// the write port and the read port are each granted independently with a
// round-robin tie-break. Read responses come back tagged with the client id.
//
// Handshake: a client holds cN_req (and we/addr/wdata) stable until it sees
// cN_ready; a transfer happens on the posedge where cN_req and cN_ready are
// both 1. cN_ready is combinational from the current requests and arbiter state.
// Responses (rsp_valid) have no back-pressure and arrive in acceptance order.
module dual_port_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 512,
    parameter int ADD_WIDTH = 9,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 c0_req,
    input  logic                 c0_we,
    input  logic [ADD_WIDTH-1:0] c0_addr,
    input  logic [WIDTH-1:0]     c0_wdata,
    output logic                 c0_ready,
    input  logic                 c1_req,
    input  logic                 c1_we,
    input  logic [ADD_WIDTH-1:0] c1_addr,
    input  logic [WIDTH-1:0]     c1_wdata,
    output logic                 c1_ready,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 init_done,
    output logic                 mem_wr_en,
    output logic [ADD_WIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_rd_en,
    output logic [ADD_WIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]     mem_rdata
);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADD_WIDTH-1:0] r_clr_addr;
    logic                 r_wr_ptr;   // client that wins the write port on contention
    logic                 r_rd_ptr;   // client that wins the read port on contention

    logic                 r_mem_wr_en;
    logic [ADD_WIDTH-1:0] r_mem_wr_addr;
    logic [WIDTH-1:0]     r_mem_wdata;
    logic                 r_mem_rd_en;
    logic [ADD_WIDTH-1:0] r_mem_rd_addr;
    logic                 r_rd_id;    // id of the read currently on the memory read port

    logic [RD_LAT-1:0]    r_pipe_v;
    logic [RD_LAT-1:0]    r_pipe_id;

    logic w_run;
    logic w_wreq0, w_wreq1, w_rreq0, w_rreq1;
    logic w_gnt_w0, w_gnt_w1, w_gnt_r0, w_gnt_r1;

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave CLEAR on the edge that issues the last address; RUN is left only by reset.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_clr_addr == ADD_WIDTH'(DEPTH - 1)) begin
            w_state_nxt = S_RUN;
        end
    end

    // Per-port arbitration; grants are only possible in RUN.
    always_comb begin
        w_run    = (r_state == S_RUN);
        w_wreq0  = c0_req & c0_we;
        w_wreq1  = c1_req & c1_we;
        w_rreq0  = c0_req & ~c0_we;
        w_rreq1  = c1_req & ~c1_we;
        w_gnt_w0 = w_run & w_wreq0 & (~w_wreq1 | ~r_wr_ptr);
        w_gnt_w1 = w_run & w_wreq1 & (~w_wreq0 |  r_wr_ptr);
        w_gnt_r0 = w_run & w_rreq0 & (~w_rreq1 | ~r_rd_ptr);
        w_gnt_r1 = w_run & w_rreq1 & (~w_rreq0 |  r_rd_ptr);
    end

    assign c0_ready  = w_gnt_w0 | w_gnt_r0;
    assign c1_ready  = w_gnt_w1 | w_gnt_r1;
    assign init_done = (r_state == S_RUN);

    // Registered memory-side outputs: clear writes in CLEAR, granted transfers in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clr_addr    <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wdata   <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_rd_id       <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_addr <= r_clr_addr;
            r_mem_wdata   <= '0;
            r_mem_rd_en   <= 1'b0;
            r_clr_addr    <= r_clr_addr + ADD_WIDTH'(1);
        end else begin
            r_mem_wr_en <= w_gnt_w0 | w_gnt_w1;
            if (w_gnt_w0) begin
                r_mem_wr_addr <= c0_addr;
                r_mem_wdata   <= c0_wdata;
                r_wr_ptr      <= 1'b1;
            end else if (w_gnt_w1) begin
                r_mem_wr_addr <= c1_addr;
                r_mem_wdata   <= c1_wdata;
                r_wr_ptr      <= 1'b0;
            end
            r_mem_rd_en <= w_gnt_r0 | w_gnt_r1;
            if (w_gnt_r0) begin
                r_mem_rd_addr <= c0_addr;
                r_rd_id       <= 1'b0;
                r_rd_ptr      <= 1'b1;
            end else if (w_gnt_r1) begin
                r_mem_rd_addr <= c1_addr;
                r_rd_id       <= 1'b1;
                r_rd_ptr      <= 1'b0;
            end
        end
    end

    // Response tag pipeline: tracks each issued read through the memory's RD_LAT edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pipe_v  <= '0;
            r_pipe_id <= '0;
        end else begin
            r_pipe_v[0]  <= r_mem_rd_en;
            r_pipe_id[0] <= r_rd_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
        end
    end

    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_addr = r_mem_wr_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign rsp_valid   = r_pipe_v[RD_LAT-1];
    assign rsp_id      = r_pipe_id[RD_LAT-1];
    assign rsp_data    = mem_rdata;

endmodule

// File: tb/tb_dual_port_arbiter.sv
// Bench for dual_port_arbiter: stand-in dual-port memory, a golden model
// (address array + response queue) checked every cycle, and directed scenarios
// with literal expectations.
module tb_dual_port_arbiter;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 512;
    localparam int ADD_WIDTH = 9;
    localparam int RD_LAT    = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 c0_req, c0_we, c1_req, c1_we;
    logic [ADD_WIDTH-1:0] c0_addr, c1_addr;
    logic [WIDTH-1:0]     c0_wdata, c1_wdata;
    logic                 c0_ready, c1_ready;
    logic                 rsp_valid, rsp_id, init_done;
    logic [WIDTH-1:0]     rsp_data;
    logic                 mem_wr_en, mem_rd_en;
    logic [ADD_WIDTH-1:0] mem_wr_addr, mem_rd_addr;
    logic [WIDTH-1:0]     mem_wdata, mem_rdata;

    dual_port_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADD_WIDTH(ADD_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_ready(c0_ready),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_ready(c1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .init_done(init_done),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rdata(mem_rdata)
    );

    // ---------------- stand-in dual-port memory ----------------
    logic             fill;
    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] rd_pipe [RD_LAT];

    // Filled with nonzero junk first so the clear sweep is observable.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'($urandom_range(1, 255));
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            if (mem_wr_en) mem[mem_wr_addr] <= mem_wdata;
            if (mem_rd_en) rd_pipe[0] <= mem[mem_rd_addr];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [WIDTH-1:0]     gold [DEPTH];
    logic [WIDTH:0]       exp_q[$];   // {id, data}
    int                   due_q[$];   // cycle in which that response must appear
    int                   clr_cnt = 0; // edges since reset release
    int                   mcyc    = 0;
    bit                   wr_turn = 0, rd_turn = 0;
    logic                 pend_wr = 0, pend_rd = 0;
    logic [ADD_WIDTH-1:0] pend_wa = '0, pend_ra = '0;
    logic [WIDTH-1:0]     pend_wd = '0;

    always @(negedge clk) begin
        logic run, w0, w1, r0, r1, gw0, gw1, gr0, gr1, ev;
        logic [WIDTH:0] e;
        run = (clr_cnt >= DEPTH);
        w0  = c0_req & c0_we;   w1 = c1_req & c1_we;
        r0  = c0_req & !c0_we;  r1 = c1_req & !c1_we;
        // on contention the client whose turn it is wins; an uncontested client always wins
        gw0 = run & w0 & (!w1 || wr_turn == 0);
        gw1 = run & w1 & (!w0 || wr_turn == 1);
        gr0 = run & r0 & (!r1 || rd_turn == 0);
        gr1 = run & r1 & (!r0 || rd_turn == 1);

        chk("init_done", init_done, run);
        chk("c0_ready", c0_ready, gw0 | gr0);
        chk("c1_ready", c1_ready, gw1 | gr1);

        if (clr_cnt >= 1 && clr_cnt <= DEPTH) begin
            chk("clr_wr_en", mem_wr_en, 1);
            chk("clr_wr_addr", mem_wr_addr, clr_cnt - 1);
            chk("clr_wdata", mem_wdata, 0);
        end else begin
            chk("mem_wr_en", mem_wr_en, pend_wr);
            if (pend_wr) begin
                chk("mem_wr_addr", mem_wr_addr, pend_wa);
                chk("mem_wdata", mem_wdata, pend_wd);
            end
        end
        chk("mem_rd_en", mem_rd_en, pend_rd);
        if (pend_rd) chk("mem_rd_addr", mem_rd_addr, pend_ra);

        ev = (due_q.size() > 0 && due_q[0] <= mcyc);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            chk("rsp_id", rsp_id, e[WIDTH]);
            chk("rsp_data", rsp_data, e[WIDTH-1:0]);
        end

        if (!rst) begin
            clr_cnt = 0; wr_turn = 0; rd_turn = 0;
            pend_wr = 0; pend_rd = 0;
            exp_q.delete(); due_q.delete();
            for (int i = 0; i < DEPTH; i++) gold[i] = '0;
        end else begin
            if (clr_cnt <= DEPTH) clr_cnt++;
            // reads see memory before any write accepted in the same cycle
            if (gr0) begin exp_q.push_back({1'b0, gold[c0_addr]}); due_q.push_back(mcyc + RD_LAT + 1); end
            if (gr1) begin exp_q.push_back({1'b1, gold[c1_addr]}); due_q.push_back(mcyc + RD_LAT + 1); end
            pend_rd = gr0 | gr1;
            pend_ra = gr0 ? c0_addr : c1_addr;
            if (gw0) gold[c0_addr] = c0_wdata;
            if (gw1) gold[c1_addr] = c1_wdata;
            pend_wr = gw0 | gw1;
            pend_wa = gw0 ? c0_addr : c1_addr;
            pend_wd = gw0 ? c0_wdata : c1_wdata;
            if (gw0) wr_turn = 1; else if (gw1) wr_turn = 0;
            if (gr0) rd_turn = 1; else if (gr1) rd_turn = 0;
        end
        mcyc++;
    end

    // ---------------- response log for literal checks ----------------
    logic [WIDTH:0] log_q[$];
    int             log_cyc[$];
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            log_q.push_back({rsp_id, rsp_data});
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    int acc0, acc1;

    // Present one request per client (either may be idle) and wait for acceptance.
    // Called and returns at posedge+1.
    task automatic pair_op(input logic e0, input logic we0, input logic [ADD_WIDTH-1:0] a0,
                           input logic [WIDTH-1:0] d0,
                           input logic e1, input logic we1, input logic [ADD_WIDTH-1:0] a1,
                           input logic [WIDTH-1:0] d1);
        logic p0, p1;
        int   n;
        c0_req = e0; c0_we = we0; c0_addr = a0; c0_wdata = d0;
        c1_req = e1; c1_we = we1; c1_addr = a1; c1_wdata = d1;
        p0 = e0; p1 = e1; n = 0;
        while ((p0 || p1) && n < 20) begin
            @(negedge clk);
            if (p0 && c0_ready) begin p0 = 0; acc0 = cyc; end
            if (p1 && c1_ready) begin p1 = 0; acc1 = cyc; end
            @(posedge clk); #1;
            if (!p0) c0_req = 0;
            if (!p1) c1_req = 0;
            n++;
        end
        chk("accept_in_time", {p0, p1}, 0);
        c0_req = 0; c1_req = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_rsp(input string name, input int base, input logic id,
                             input logic [WIDTH-1:0] data, input int acc);
        chk({name, "_count"}, log_q.size() - base, 1);
        if (log_q.size() > base) begin
            chk({name, "_id"}, log_q[base][WIDTH], id);
            chk({name, "_data"}, log_q[base][WIDTH-1:0], data);
            chk({name, "_latency"}, log_cyc[base] - acc, RD_LAT + 1);
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk(name, init_done, 1);
    endtask

    // ---------------- directed scenarios ----------------
    int exp_g[4] = '{0, 1, 0, 1};

    initial begin
        int lowcnt, bad, base, g;

        rst = 0; fill = 1;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;

        // 1+3: two reset edges with both clients already requesting writes
        @(posedge clk); #1;
        fill = 0;
        c0_req = 1; c0_we = 1; c0_addr = 9'h100; c0_wdata = 8'hB0;
        c1_req = 1; c1_we = 1; c1_addr = 9'h180; c1_wdata = 8'hC0;
        @(posedge clk); #1;
        rst = 1;
        lowcnt = 0;
        @(negedge clk);
        while (init_done !== 1'b1 && lowcnt < 1000) begin
            if (c0_ready !== 1'b0) chk("ready_during_clear", c0_ready, 0);
            lowcnt++;
            @(negedge clk);
        end
        chk("clear_cycles", lowcnt, DEPTH);

        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("one_write_grant", c0_ready ^ c1_ready, 1);
            g = c1_ready ? 1 : 0;
            chk("grant_order", g, exp_g[i]);
            @(posedge clk); #1;
            if (g == 1) begin c1_addr = c1_addr + 1; c1_wdata = c1_wdata + 1; end
            else        begin c0_addr = c0_addr + 1; c0_wdata = c0_wdata + 1; end
            if (i == 3) begin c0_req = 0; c1_req = 0; end
        end
        idle(4);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (a != 'h100 && a != 'h101 && a != 'h180 && a != 'h181 && mem[a] !== '0) bad++;
        end
        chk("clear_all_zero", bad, 0);
        chk("wr_c0_100", mem[9'h100], 8'hB0);
        chk("wr_c0_101", mem[9'h101], 8'hB1);
        chk("wr_c1_180", mem[9'h180], 8'hC0);
        chk("wr_c1_181", mem[9'h181], 8'hC1);

        // 2: write then read back on client 0
        pair_op(1, 1, 9'h005, 8'hA5, 0, 0, '0, '0);
        base = log_q.size();
        pair_op(1, 0, 9'h005, 8'h00, 0, 0, '0, '0);
        idle(4);
        check_rsp("rd_005", base, 1'b0, 8'hA5, acc0);

        // 4: simultaneous write (c0) and read (c1) to different addresses
        pair_op(0, 0, '0, '0, 1, 1, 9'h011, 8'h77);
        base = log_q.size();
        pair_op(1, 1, 9'h010, 8'h3C, 1, 0, 9'h011, 8'h00);
        chk("same_cycle_accept", acc1 - acc0, 0);
        idle(4);
        check_rsp("rd_011", base, 1'b1, 8'h77, acc1);

        // 5: same-address write and read in one cycle return old data, then new
        pair_op(1, 1, 9'h020, 8'h11, 0, 0, '0, '0);
        base = log_q.size();
        pair_op(1, 1, 9'h020, 8'h22, 1, 0, 9'h020, 8'h00);
        idle(4);
        check_rsp("rd_020_old", base, 1'b1, 8'h11, acc1);
        base = log_q.size();
        pair_op(1, 0, 9'h020, 8'h00, 0, 0, '0, '0);
        idle(4);
        check_rsp("rd_020_new", base, 1'b0, 8'h22, acc0);
        chk("mem_010", mem[9'h010], 8'h3C);

        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== gold[a]) bad++;
        chk("mem_vs_model", bad, 0);

        // 6: reset right after a read is accepted drops the response
        base = log_q.size();
        pair_op(0, 0, '0, '0, 1, 0, 9'h020, 8'h00);
        rst = 0;
        idle(2);
        rst = 1;
        @(negedge clk);
        chk("init_done_after_rst", init_done, 0);
        chk("wr_en_after_rst", mem_wr_en, 0);
        @(negedge clk);
        chk("restart_wr_en", mem_wr_en, 1);
        chk("restart_addr", mem_wr_addr, 0);
        idle(20);
        chk("dropped_rsp", log_q.size() - base, 0);
        wait_init("reinit_done");
        idle(4);
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== '0) bad++;
        chk("reclear_all_zero", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
        $fatal(1);
    end

endmodule
